// File: rtl/axi_4_defs.sv
// Shared AXI4 definitions: FSM state encodings and response codes.
package axi_4_defs;

    localparam int unsigned AXI_RESP_W = 2;

    localparam logic [AXI_RESP_W-1:0] OKAY   = 2'b00;
    localparam logic [AXI_RESP_W-1:0] EXOKAY = 2'b01;
    localparam logic [AXI_RESP_W-1:0] SLVERR = 2'b10;
    localparam logic [AXI_RESP_W-1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ADDR = 2'd1,
        RD_DATA = 2'd2,
        RD_DONE = 2'd3
    } axi_4_rd_states_e;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_XFER = 2'd1,
        WR_RESP = 2'd2,
        WR_DONE = 2'd3
    } axi_4_wr_states_e;

endpackage

// File: rtl/axi_4_master_burst_ctrl_if.sv
// AXI4 handshake bundle between the burst controller (master) and the slave side.
interface axi_4_master_burst_ctrl_if #(
    parameter int unsigned RESP_W = 2
);
    logic              m_arvalid;
    logic              s_arready;
    logic              s_rvalid;
    logic              s_rlast;
    logic [RESP_W-1:0] s_rresp;
    logic              m_rready;
    logic              m_awvalid;
    logic              s_awready;
    logic              m_wvalid;
    logic              m_wlast;
    logic              s_wready;
    logic              s_bvalid;
    logic [RESP_W-1:0] s_bresp;
    logic              m_bready;

    modport master (
        output m_arvalid, m_rready, m_awvalid, m_wvalid, m_wlast, m_bready,
        input  s_arready, s_rvalid, s_rlast, s_rresp, s_awready, s_wready, s_bvalid, s_bresp
    );

    modport slave (
        input  m_arvalid, m_rready, m_awvalid, m_wvalid, m_wlast, m_bready,
        output s_arready, s_rvalid, s_rlast, s_rresp, s_awready, s_wready, s_bvalid, s_bresp
    );
endinterface

// File: rtl/axi_4_beat_counter.sv
// Burst beat counter: latches the length on clear, flags the final beat.
module axi_4_beat_counter #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic [LEN_W-1:0] len,
    output logic             is_last
);
    // One extra bit so a full 2^LEN_W-beat burst never wraps.
    localparam int unsigned CNT_W = LEN_W + 1;

    logic [CNT_W-1:0] count;
    logic [LEN_W-1:0] len_q;

    // Count register and latched length.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            len_q <= '0;
        end else if (clear) begin
            count <= '0;
            len_q <= len;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign is_last = (count == {1'b0, len_q});
endmodule

// File: rtl/axi_4_master_burst_ctrl.sv
// AXI4 master handshake controller with independent, concurrent read and write engines.
module axi_4_master_burst_ctrl #(
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned RESP_W = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ld_req,
    input  logic [LEN_W-1:0]              ld_len,
    input  logic                          st_req,
    input  logic [LEN_W-1:0]              st_len,
    output logic                          ld_busy,
    output logic                          st_busy,
    output logic                          ld_done,
    output logic                          st_done,
    output logic                          ld_err,
    output logic                          st_err,
    output logic                          ld_len_err,
    output logic                          incre_rdata,
    output logic                          incre_wdata,
    axi_4_master_burst_ctrl_if.master     bus
);
    import axi_4_defs::*;

    axi_4_rd_states_e rd_state, rd_state_n;
    axi_4_wr_states_e wr_state, wr_state_n;

    logic r_err, r_err_n, len_err, len_err_n;
    logic aw_done, aw_done_n, w_done, w_done_n, b_err, b_err_n;
    logic rd_clear, wr_clear, rd_last, wr_last;
    logic ar_valid, r_ready, aw_valid, w_valid, w_last, b_ready;

    axi_4_beat_counter #(.LEN_W(LEN_W)) u_rd_cnt (
        .clk(clk), .reset(reset), .clear(rd_clear), .inc(incre_rdata),
        .len(ld_len), .is_last(rd_last)
    );

    axi_4_beat_counter #(.LEN_W(LEN_W)) u_wr_cnt (
        .clk(clk), .reset(reset), .clear(wr_clear), .inc(incre_wdata),
        .len(st_len), .is_last(wr_last)
    );

    // State and flag registers for both engines.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state <= RD_IDLE;
            wr_state <= WR_IDLE;
            r_err    <= 1'b0;
            len_err  <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            b_err    <= 1'b0;
        end else begin
            rd_state <= rd_state_n;
            wr_state <= wr_state_n;
            r_err    <= r_err_n;
            len_err  <= len_err_n;
            aw_done  <= aw_done_n;
            w_done   <= w_done_n;
            b_err    <= b_err_n;
        end
    end

    // Read engine next-state and outputs.
    always_comb begin
        rd_state_n  = rd_state;
        r_err_n     = r_err;
        len_err_n   = len_err;
        rd_clear    = 1'b0;
        ar_valid    = 1'b0;
        r_ready     = 1'b0;
        incre_rdata = 1'b0;
        ld_done     = 1'b0;
        ld_err      = 1'b0;
        ld_len_err  = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                if (ld_req) begin
                    rd_clear   = 1'b1;
                    r_err_n    = 1'b0;
                    len_err_n  = 1'b0;
                    rd_state_n = RD_ADDR;
                end
            end
            RD_ADDR: begin
                ar_valid = 1'b1;
                if (bus.s_arready) rd_state_n = RD_DATA;
            end
            RD_DATA: begin
                r_ready = 1'b1;
                if (bus.s_rvalid) begin
                    incre_rdata = 1'b1;
                    if (bus.s_rresp[RESP_W-1]) r_err_n = 1'b1;
                    // Burst ends on the counted beat regardless of RLAST.
                    if (rd_last) begin
                        if (!bus.s_rlast) len_err_n = 1'b1;
                        rd_state_n = RD_DONE;
                    end else if (bus.s_rlast) begin
                        len_err_n = 1'b1;
                    end
                end
            end
            RD_DONE: begin
                ld_done    = 1'b1;
                ld_err     = r_err | len_err;
                ld_len_err = len_err;
                rd_state_n = RD_IDLE;
            end
            default: rd_state_n = RD_IDLE;
        endcase
    end

    // Write engine next-state and outputs; AW and W complete independently.
    always_comb begin
        wr_state_n  = wr_state;
        aw_done_n   = aw_done;
        w_done_n    = w_done;
        b_err_n     = b_err;
        wr_clear    = 1'b0;
        aw_valid    = 1'b0;
        w_valid     = 1'b0;
        w_last      = 1'b0;
        b_ready     = 1'b0;
        incre_wdata = 1'b0;
        st_done     = 1'b0;
        st_err      = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                if (st_req) begin
                    wr_clear   = 1'b1;
                    aw_done_n  = 1'b0;
                    w_done_n   = 1'b0;
                    b_err_n    = 1'b0;
                    wr_state_n = WR_XFER;
                end
            end
            WR_XFER: begin
                aw_valid = !aw_done;
                w_valid  = !w_done;
                w_last   = w_valid & wr_last;
                if (aw_valid && bus.s_awready) aw_done_n = 1'b1;
                if (w_valid && bus.s_wready) begin
                    incre_wdata = 1'b1;
                    if (wr_last) w_done_n = 1'b1;
                end
                if (aw_done_n && w_done_n) wr_state_n = WR_RESP;
            end
            WR_RESP: begin
                b_ready = 1'b1;
                if (bus.s_bvalid) begin
                    b_err_n    = bus.s_bresp[RESP_W-1];
                    wr_state_n = WR_DONE;
                end
            end
            WR_DONE: begin
                st_done    = 1'b1;
                st_err     = b_err;
                wr_state_n = WR_IDLE;
            end
            default: wr_state_n = WR_IDLE;
        endcase
    end

    assign ld_busy       = (rd_state != RD_IDLE);
    assign st_busy       = (wr_state != WR_IDLE);
    assign bus.m_arvalid = ar_valid;
    assign bus.m_rready  = r_ready;
    assign bus.m_awvalid = aw_valid;
    assign bus.m_wvalid  = w_valid;
    assign bus.m_wlast   = w_last;
    assign bus.m_bready  = b_ready;
endmodule

// File: tb/tb_axi_4_master_burst_ctrl.sv
// Self-checking bench: vector tables, done-pulse scoreboard, AXI stability assertions.
module tb_axi_4_master_burst_ctrl;
    import axi_4_defs::*;

    logic       clk = 1'b0;
    logic       reset, ld_req, st_req;
    logic [7:0] ld_len, st_len;
    logic       ld_busy, st_busy, ld_done, st_done, ld_err, st_err, ld_len_err;
    logic       incre_rdata, incre_wdata;

    int errors = 0;
    int checks = 0;

    axi_4_master_burst_ctrl_if #(.RESP_W(2)) bus ();

    axi_4_master_burst_ctrl #(.LEN_W(8), .RESP_W(2)) dut (
        .clk(clk), .reset(reset),
        .ld_req(ld_req), .ld_len(ld_len), .st_req(st_req), .st_len(st_len),
        .ld_busy(ld_busy), .st_busy(st_busy), .ld_done(ld_done), .st_done(st_done),
        .ld_err(ld_err), .st_err(st_err), .ld_len_err(ld_len_err),
        .incre_rdata(incre_rdata), .incre_wdata(incre_wdata),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Scoreboard of expected completions.
    typedef struct {
        int beats;
        bit err;
        bit len_err;
    } exp_t;

    exp_t ld_q[$];
    exp_t st_q[$];
    exp_t mon_e;
    int   rd_beats = 0;
    int   wr_beats = 0;

    always @(negedge clk) begin
        if (reset) begin
            rd_beats = 0;
            wr_beats = 0;
        end else begin
            if (incre_rdata) rd_beats++;
            if (incre_wdata) wr_beats++;
            if (ld_done) begin
                if (ld_q.size() == 0) check("ld_done_unexpected", 1, 0);
                else begin
                    mon_e = ld_q.pop_front();
                    check("ld_beats", rd_beats, mon_e.beats);
                    check("ld_err", ld_err, mon_e.err);
                    check("ld_len_err", ld_len_err, mon_e.len_err);
                end
                rd_beats = 0;
            end
            if (st_done) begin
                if (st_q.size() == 0) check("st_done_unexpected", 1, 0);
                else begin
                    mon_e = st_q.pop_front();
                    check("st_beats", wr_beats, mon_e.beats);
                    check("st_err", st_err, mon_e.err);
                end
                wr_beats = 0;
            end
        end
    end

    // VALID must hold until handshake; WLAST stable while WVALID waits.
    a_ar: assert property (@(posedge clk) disable iff (reset)
        (bus.m_arvalid && !bus.s_arready) |=> bus.m_arvalid)
        else begin errors++; $display("FAIL axi_ar_stable: arvalid dropped before arready"); end
    a_aw: assert property (@(posedge clk) disable iff (reset)
        (bus.m_awvalid && !bus.s_awready) |=> bus.m_awvalid)
        else begin errors++; $display("FAIL axi_aw_stable: awvalid dropped before awready"); end
    a_w: assert property (@(posedge clk) disable iff (reset)
        (bus.m_wvalid && !bus.s_wready) |=> (bus.m_wvalid && $stable(bus.m_wlast)))
        else begin errors++; $display("FAIL axi_w_stable: wvalid/wlast changed before wready"); end

    function automatic logic [14:0] all_outs();
        return {ld_busy, st_busy, ld_done, st_done, ld_err, st_err, ld_len_err,
                incre_rdata, incre_wdata, bus.m_arvalid, bus.m_rready,
                bus.m_awvalid, bus.m_wvalid, bus.m_wlast, bus.m_bready};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load transaction: slave-side driver plus timing checks.
    task automatic run_load(input int len, input int rlast_at, input int err_at,
                            input logic [1:0] eresp, input int ar_dly, input bit rnd,
                            input bit exp_err, input bit exp_len_err);
        exp_t x;
        x.beats = len + 1; x.err = exp_err; x.len_err = exp_len_err;
        ld_q.push_back(x);
        ld_len = 8'(len);
        ld_req = 1'b1;
        tick();
        ld_req = 1'b0;
        check("ld_arvalid_latency", bus.m_arvalid, 1);
        repeat (ar_dly) begin
            tick();
            check("ld_arvalid_hold", bus.m_arvalid, 1);
        end
        bus.s_arready = 1'b1;
        tick();
        bus.s_arready = 1'b0;
        for (int b = 0; b <= len; b++) begin
            if (rnd) begin
                int s;
                s = int'($urandom_range(0, 2));
                if (s > 0) begin
                    bus.s_rvalid = 1'b0;
                    repeat (s) tick();
                end
            end
            bus.s_rvalid = 1'b1;
            bus.s_rlast  = (b == rlast_at);
            bus.s_rresp  = (b == err_at) ? eresp : OKAY;
            tick();
        end
        bus.s_rvalid = 1'b0;
        bus.s_rlast  = 1'b0;
        bus.s_rresp  = OKAY;
        check("ld_done_pulse", ld_done, 1);
        tick();
        check("ld_idle_after_done", {ld_busy, ld_done}, 0);
    endtask

    // Store transaction: AW and W sides driven independently, then B.
    task automatic run_store(input int len, input int aw_dly, input logic [1:0] bresp,
                             input bit rnd, input bit exp_err);
        exp_t x;
        int   t;
        x.beats = len + 1; x.err = exp_err; x.len_err = 1'b0;
        st_q.push_back(x);
        st_len = 8'(len);
        st_req = 1'b1;
        tick();
        st_req = 1'b0;
        check("st_awvalid_latency", bus.m_awvalid, 1);
        check("st_wvalid_latency", bus.m_wvalid, 1);
        fork
            begin
                repeat (aw_dly) begin
                    tick();
                    check("st_awvalid_hold", bus.m_awvalid, 1);
                end
                bus.s_awready = 1'b1;
                tick();
                bus.s_awready = 1'b0;
                check("st_awvalid_drop", bus.m_awvalid, 0);
            end
            begin
                for (int b = 0; b <= len; b++) begin
                    if (rnd) begin
                        int s;
                        s = int'($urandom_range(0, 2));
                        if (s > 0) begin
                            bus.s_wready = 1'b0;
                            repeat (s) tick();
                        end
                    end
                    bus.s_wready = 1'b1;
                    if (b == 0 || b == len) begin
                        check("st_wvalid", bus.m_wvalid, 1);
                        check("st_wlast", bus.m_wlast, (b == len));
                    end else if (bus.m_wlast !== 1'b0 || bus.m_wvalid !== 1'b1) begin
                        check("st_wlast_mid", {bus.m_wvalid, bus.m_wlast}, 2);
                    end
                    tick();
                end
                bus.s_wready = 1'b0;
                check("st_wvalid_drop", bus.m_wvalid, 0);
            end
        join
        t = 0;
        while (!bus.m_bready && t < 50) begin
            tick();
            t++;
        end
        check("st_bready", bus.m_bready, 1);
        if (rnd) repeat (int'($urandom_range(0, 3))) tick();
        bus.s_bvalid = 1'b1;
        bus.s_bresp  = bresp;
        tick();
        bus.s_bvalid = 1'b0;
        bus.s_bresp  = OKAY;
        check("st_done_pulse", st_done, 1);
        tick();
        check("st_idle_after_done", {st_busy, st_done}, 0);
    endtask

    typedef struct {
        int         len;
        int         rlast_at;
        int         err_at;
        logic [1:0] resp;
        int         ar_dly;
        bit         rnd;
        bit         exp_err;
        bit         exp_len_err;
    } ld_vec_t;

    typedef struct {
        int         len;
        int         aw_dly;
        logic [1:0] resp;
        bit         rnd;
        bit         exp_err;
    } st_vec_t;

    ld_vec_t ld_tab[6];
    st_vec_t st_tab[6];

    initial begin
        ld_tab[0] = '{3, 3, -1, OKAY,   0, 1'b0, 1'b0, 1'b0};
        ld_tab[1] = '{3, 1, -1, OKAY,   0, 1'b0, 1'b1, 1'b1};
        ld_tab[2] = '{0, 0,  0, SLVERR, 0, 1'b0, 1'b1, 1'b0};
        ld_tab[3] = '{5, -1, -1, OKAY,  2, 1'b0, 1'b1, 1'b1};
        ld_tab[4] = '{2, 2,  1, DECERR, 3, 1'b1, 1'b1, 1'b0};
        ld_tab[5] = '{1, 1,  0, EXOKAY, 1, 1'b1, 1'b0, 1'b0};

        st_tab[0] = '{0,   5, OKAY,   1'b0, 1'b0};
        st_tab[1] = '{3,   0, SLVERR, 1'b0, 1'b1};
        st_tab[2] = '{3,   0, OKAY,   1'b0, 1'b0};
        st_tab[3] = '{7,   1, DECERR, 1'b1, 1'b1};
        st_tab[4] = '{2,   9, EXOKAY, 1'b0, 1'b0};
        st_tab[5] = '{255, 0, OKAY,   1'b0, 1'b0};

        reset = 1'b1; ld_req = 1'b0; st_req = 1'b0; ld_len = '0; st_len = '0;
        bus.s_arready = 1'b0; bus.s_rvalid = 1'b0; bus.s_rlast = 1'b0; bus.s_rresp = OKAY;
        bus.s_awready = 1'b0; bus.s_wready = 1'b0; bus.s_bvalid = 1'b0; bus.s_bresp = OKAY;
        repeat (3) tick();
        check("reset_outputs", all_outs(), 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++)
            run_load(ld_tab[i].len, ld_tab[i].rlast_at, ld_tab[i].err_at, ld_tab[i].resp,
                     ld_tab[i].ar_dly, ld_tab[i].rnd, ld_tab[i].exp_err, ld_tab[i].exp_len_err);

        for (int i = 0; i < 6; i++)
            run_store(st_tab[i].len, st_tab[i].aw_dly, st_tab[i].resp,
                      st_tab[i].rnd, st_tab[i].exp_err);

        // Concurrent load and store accepted in the same cycle.
        for (int k = 0; k < 3; k++) begin
            fork
                run_load(7, 7, -1, OKAY, k, 1'b1, 1'b0, 1'b0);
                run_store(7, 2 * k, OKAY, 1'b1, 1'b0);
            join
            tick();
        end

        // Request while busy is dropped: only one completion expected.
        fork
            run_load(2, 2, -1, OKAY, 4, 1'b0, 1'b0, 1'b0);
            begin
                tick();
                tick();
                ld_req = 1'b1;
                ld_len = 8'd9;
                tick();
                ld_req = 1'b0;
            end
        join
        repeat (3) tick();
        check("ld_busy_req_ignored", ld_busy, 0);

        // Reset in the middle of a write burst.
        st_len = 8'd7;
        st_req = 1'b1;
        tick();
        st_req = 1'b0;
        bus.s_wready = 1'b1;
        repeat (3) tick();
        bus.s_wready = 1'b0;
        reset = 1'b1;
        tick();
        check("reset_mid_write_outputs", all_outs(), 0);
        reset = 1'b0;
        repeat (4) tick();
        check("reset_mid_write_idle", st_busy, 0);
        run_store(7, 2, OKAY, 1'b0, 1'b0);

        repeat (3) tick();
        check("ld_scoreboard_empty", ld_q.size(), 0);
        check("st_scoreboard_empty", st_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi_4_master_burst_ctrl.md
# axi_4_master_burst_ctrl

Parametrised AXI4 master-side handshake controller for the vector load/store unit. It replaces single-transaction serialisation with independent read and write engines that run concurrently. Beat counting is internal, so the controller generates WLAST itself, checks RLAST against the requested length, and reports SLVERR/DECERR responses. It sits between the vlsu request logic and the AXI4 master datapath, which owns the address and data registers.

## Interface
Parameters:
- LEN_W, 8: width of the burst-length fields (AXI AxLEN; beats = len+1).
- RESP_W, 2: width of RRESP/BRESP.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ld_req  in  1  load request; sampled only when the read engine is idle.
- ld_len  in  LEN_W  load burst length minus 1; latched with ld_req.
- st_req  in  1  store request; sampled only when the write engine is idle.
- st_len  in  LEN_W  store burst length minus 1; latched with st_req.
- ld_busy / st_busy  out  1  engine not idle.
- ld_done / st_done  out  1  one-cycle completion pulse.
- ld_err / st_err  out  1  valid with done; response error or length error.
- ld_len_err  out  1  valid with ld_done; RLAST mismatch.
- incre_rdata / incre_wdata  out  1  datapath beat-advance strobe; equals the R/W handshake.
- m_arvalid  out  1; s_arready  in  1.
- s_rvalid  in  1; s_rlast  in  1; s_rresp  in  RESP_W; m_rready  out  1.
- m_awvalid  out  1; s_awready  in  1.
- m_wvalid  out  1; m_wlast  out  1; s_wready  in  1.
- s_bvalid  in  1; s_bresp  in  RESP_W; m_bready  out  1.

## Operation
- Read FSM states: RD_IDLE, RD_ADDR, RD_DATA, RD_DONE.
  - RD_IDLE: ld_req → latch ld_len, clear rbeat and error flags, go to RD_ADDR.
  - RD_ADDR: m_arvalid=1. On s_arready → RD_DATA.
  - RD_DATA: m_rready=1. On each s_rvalid: incre_rdata=1 and rbeat increments.
    - If rresp[1]=1, set the sticky r_err.
    - Last beat when rbeat==ld_len: go to RD_DONE.
    - Length error: s_rlast high on an earlier beat, or low on the last beat, sets len_err. The burst still ends on the counted beat.
  - RD_DONE: ld_done=1; ld_err = r_err|len_err; → RD_IDLE.
- Write FSM states: WR_IDLE, WR_XFER, WR_RESP, WR_DONE.
  - WR_IDLE: st_req → latch st_len, clear wbeat, aw_done and error flags, go to WR_XFER.
  - WR_XFER, AW side: m_awvalid = !aw_done. s_awready sets aw_done.
  - WR_XFER, W side: m_wvalid=1 until the last beat is accepted. AW and W progress independently, so W may finish before AW.
    - m_wlast = (wbeat==st_len).
    - On s_wready: incre_wdata=1 and wbeat increments.
  - Leave WR_XFER when both the last W beat and the AW handshake are complete; either may finish first, or both in the same cycle. → WR_RESP.
  - WR_RESP: m_bready=1. On s_bvalid, capture bresp[1] → WR_DONE.
  - WR_DONE: st_done=1; st_err = bresp error; → WR_IDLE.
- ld_req/st_req while busy: ignored, never queued.
- Simultaneous ld_req and st_req: both are accepted in the same cycle.
- Beat counters are LEN_W+1 bits wide, so len=2^LEN_W−1 gives 2^LEN_W beats with no wrap.

## Timing
- All VALID/READY outputs are Moore-decoded from registered state and flags. incre_* and m_wlast combine with the slave inputs.
- Request sampled at edge N → m_arvalid/m_awvalid/m_wvalid high in cycle N+1. Minimum latency: 1 cycle.
- VALID, once raised, stays high until its handshake completes; m_wlast is stable while m_wvalid is high.
- Last R or B handshake at edge M → done pulse in cycle M+1 → idle in cycle M+2. A new request is accepted in that idle cycle.
- Reset (synchronous): at the next edge, both FSMs go to IDLE and counters and flags clear. All outputs are 0, including mid-burst; no partial done.

## Structure
- Add to the shared axi_4_defs package:
  - enums axi_4_rd_states_e and axi_4_wr_states_e;
  - RESP constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
- Sub-module axi_4_beat_counter: clear, increment, compare-to-length, is_last output. Instantiated once per engine.

## Test plan
- Load, ld_len=3, slave ready immediately, RLAST on beat 4 → arvalid in cycle 1; 4 incre_rdata; ld_done 1 cycle after beat 4; ld_err=0.
- Store, st_len=0, awready delayed 5 cycles, wready immediate → W completes first; m_wlast=1 on the single beat; awvalid held 5 cycles; then bready; st_done after bvalid.
- Concurrent ld_req and st_req in one cycle, lengths 7/7, random ready/valid stalls → both complete; 8 beats each; AXI VALID-stability assertions hold.
- RLAST asserted on beat 2 of ld_len=3 → 4 beats still consumed; ld_len_err=1 and ld_err=1 with ld_done.
- bresp=SLVERR → st_err=1 with st_done. Next store with OKAY → st_err=0.
- reset asserted mid-write at beat 3 of 8 → all outputs 0 next cycle; no st_done; a new st_req after release completes normally.
